// File: rtl/sse_pair_feeder.sv
// Input stage for the SSE accumulator: buffers (A, B) sample pairs, hands them out on `next`,
// pulses sse_rst at frame start and raises stop after the last pair. Optional macro: SSE_FEEDER_COUNT_EN.
module sse_pair_feeder #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic         sse_rst,
  input  logic         next,
  output logic         stop,
  input  logic         result_taken,
  output logic         underrun,
  output logic [15:0]  pair_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        state;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [2*W:0]  mem [DEPTH];
  logic [2*W:0]  head;
  logic          cur_last, pend;
  logic          empty, full, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      STREAM:  pop = !empty && (pend || (next && !cur_last));
      default: pop = 1'b0;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_last <= 1'b0;
      A        <= '0;
      B        <= '0;
    end else if (pop) begin
      {cur_last, A, B} <= head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sse_rst  <= 1'b0;
      stop     <= 1'b0;
      pend     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sse_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            sse_rst <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          // While a request is pending, further `next` pulses are absorbed.
          if (pend) begin
            if (!empty) pend <= 1'b0;
          end else if (next) begin
            if (cur_last) begin
              stop  <= 1'b1;
              state <= DONE;
            end else if (empty) begin
              pend     <= 1'b1;
              underrun <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_taken) begin
            stop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SSE_FEEDER_COUNT_EN
  logic [15:0] count_q;

  // The IDLE pop opens a new frame, so it restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (pop) begin
      if (state == IDLE)             count_q <= 16'd1;
      else if (count_q != 16'hFFFF)  count_q <= count_q + 16'd1;
    end
  end

  assign pair_count = count_q;
`else
  assign pair_count = '0;
`endif

endmodule
